// File: rtl/ctrl_pkg.sv
// Shared opcode codes, sequencer state encoding and strobe decode for ctrl_fsm_ws.
// The IRQ_ENTRY state only exists when CTRL_IRQ_EN is defined.
package ctrl_pkg;

    localparam logic [3:0] OP_HLT  = 4'h0;
    localparam logic [3:0] OP_SKZ  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_STO  = 4'h9;
    localparam logic [3:0] OP_LDA  = 4'hA;
    localparam logic [3:0] OP_RL   = 4'hB;
    localparam logic [3:0] OP_RR   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_POP  = 4'hE;
    localparam logic [3:0] OP_PUSH = 4'hF;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_LATCH_IR  = 4'd2,
        ST_DECODE    = 4'd3,
        ST_OPERAND   = 4'd4,
        ST_EXEC      = 4'd5,
        ST_STORE     = 4'd6,
        ST_JUMP      = 4'd7,
        ST_SKIP      = 4'd8,
        ST_HALTED    = 4'd9,
        ST_ERROR     = 4'd10
`ifdef CTRL_IRQ_EN
        , ST_IRQ_ENTRY = 4'd11
`endif
    } state_e;

    typedef struct packed {
        logic inc_pc;
        logic load_acc;
        logic load_pc;
        logic rd;
        logic wr;
        logic load_ir;
        logic datactl_ena;
        logic halt;
        logic bus_err;
        logic irq_ack;
        logic busy;
    } strobes_t;

    function automatic logic is_alu_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR, OP_NOT,
            OP_LDA, OP_RL, OP_RR, OP_POP, OP_PUSH: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // Strobe set that is valid for the whole time the sequencer sits in s.
    function automatic strobes_t strobes_for(input state_e s);
        strobes_t o;
        o = '0;
        case (s)
            ST_FETCH:    begin o.rd = 1'b1; o.busy = 1'b1; end
            ST_LATCH_IR: begin o.rd = 1'b1; o.load_ir = 1'b1; o.inc_pc = 1'b1; o.busy = 1'b1; end
            ST_DECODE:   o.busy = 1'b1;
            ST_OPERAND:  begin o.rd = 1'b1; o.busy = 1'b1; end
            ST_EXEC:     begin o.rd = 1'b1; o.load_acc = 1'b1; o.busy = 1'b1; end
            ST_STORE:    begin o.wr = 1'b1; o.datactl_ena = 1'b1; o.busy = 1'b1; end
            ST_JUMP:     begin o.load_pc = 1'b1; o.busy = 1'b1; end
            ST_SKIP:     begin o.inc_pc = 1'b1; o.busy = 1'b1; end
            ST_HALTED:   o.halt = 1'b1;
            ST_ERROR:    begin o.halt = 1'b1; o.bus_err = 1'b1; end
`ifdef CTRL_IRQ_EN
            ST_IRQ_ENTRY: begin o.load_pc = 1'b1; o.irq_ack = 1'b1; o.busy = 1'b1; end
`endif
            default:     o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_fsm_ws_if.sv
// Handshake and strobe bundle between the control sequencer (master) and the datapath (slave).
interface ctrl_fsm_ws_if #(
    parameter int OPCODE_W = 4
);
    logic                ena;
    logic                zero;
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                irq;

    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
    logic bus_err;
    logic irq_ack;
    logic busy;

    modport master (
        input  ena, zero, opcode, mem_ready, irq,
        output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
               halt, bus_err, irq_ack, busy
    );

    modport slave (
        output ena, zero, opcode, mem_ready, irq,
        input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
               halt, bus_err, irq_ack, busy
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Consecutive wait-cycle counter for memory phases; expired flags a bus timeout.
// TIMEOUT of 0 removes the counter and never expires.
module ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr, cnt_en, ready};
            assign expired       = 1'b0;
        end else begin : g_on
            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clr) begin
                    count_d = '0;
                end else if (cnt_en && !ready && (count_q != CNT_W'(TIMEOUT))) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = cnt_en && !ready && (count_q == CNT_W'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/ctrl_fsm_ws.sv
// Multi-cycle control sequencer with memory wait handshake, bus timeout and sticky halt/error.
// Define CTRL_IRQ_EN to add interrupt entry at instruction boundaries.
module ctrl_fsm_ws
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    ctrl_fsm_ws_if.master bus
);

    state_e   state_q;
    state_e   state_d;
    state_e   fetch_next;
    strobes_t out_q;
    strobes_t out_d;
    logic     [3:0] op_base;
    logic     op_wide;
    logic     timer_clr;
    logic     timer_en;
    logic     expired;

    assign op_base = bus.opcode[3:0];

    // Any opcode with bits set above the base nibble is treated as a no-op.
    generate
        if (OPCODE_W > 4) begin : g_wide
            assign op_wide = |bus.opcode[OPCODE_W-1:4];
        end else begin : g_narrow
            assign op_wide = 1'b0;
        end
    endgenerate

    assign timer_clr = (state_d != state_q);
    assign timer_en  = (state_q == ST_FETCH) || (state_q == ST_OPERAND) || (state_q == ST_STORE);

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .cnt_en  (timer_en),
        .ready   (bus.mem_ready),
        .expired (expired)
    );

`ifdef CTRL_IRQ_EN
    assign fetch_next = bus.irq ? ST_IRQ_ENTRY : ST_FETCH;
`else
    logic unused_irq;
    assign unused_irq = bus.irq;
    assign fetch_next = ST_FETCH;
`endif

    always_comb begin
        state_d = state_q;
        if (!bus.ena) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready)  state_d = ST_LATCH_IR;
                    else if (expired)   state_d = ST_ERROR;
                end
                ST_LATCH_IR: state_d = ST_DECODE;
                ST_DECODE: begin
                    if (op_wide) begin
                        state_d = fetch_next;
                    end else begin
                        case (op_base)
                            OP_HLT:  state_d = ST_HALTED;
                            OP_SKZ:  state_d = bus.zero ? ST_SKIP : fetch_next;
                            OP_JMP:  state_d = ST_JUMP;
                            OP_STO:  state_d = ST_STORE;
                            default: state_d = is_alu_class(op_base) ? ST_OPERAND : fetch_next;
                        endcase
                    end
                end
                ST_OPERAND: begin
                    if (bus.mem_ready)  state_d = ST_EXEC;
                    else if (expired)   state_d = ST_ERROR;
                end
                ST_EXEC:     state_d = fetch_next;
                ST_STORE: begin
                    if (bus.mem_ready)  state_d = fetch_next;
                    else if (expired)   state_d = ST_ERROR;
                end
                ST_JUMP:     state_d = fetch_next;
                ST_SKIP:     state_d = fetch_next;
                ST_HALTED:   state_d = ST_HALTED;
                ST_ERROR:    state_d = ST_ERROR;
`ifdef CTRL_IRQ_EN
                ST_IRQ_ENTRY: state_d = ST_FETCH;
`endif
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    assign out_d = strobes_for(state_d);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign bus.inc_pc      = out_q.inc_pc;
    assign bus.load_acc    = out_q.load_acc;
    assign bus.load_pc     = out_q.load_pc;
    assign bus.rd          = out_q.rd;
    assign bus.wr          = out_q.wr;
    assign bus.load_ir     = out_q.load_ir;
    assign bus.datactl_ena = out_q.datactl_ena;
    assign bus.halt        = out_q.halt;
    assign bus.bus_err     = out_q.bus_err;
    assign bus.irq_ack     = out_q.irq_ack;
    assign bus.busy        = out_q.busy;

endmodule

// File: tb/tb_ctrl_fsm_ws.sv
// Directed bench for ctrl_fsm_ws: an instruction-level model queues the expected strobe set per cycle.
// Build with CTRL_IRQ_EN defined to exercise interrupt entry.
module tb_ctrl_fsm_ws;

    localparam int OPW = 5;
    localparam int TMO = 15;

    localparam int B_INC  = 0;
    localparam int B_ACC  = 1;
    localparam int B_LPC  = 2;
    localparam int B_RD   = 3;
    localparam int B_WR   = 4;
    localparam int B_IR   = 5;
    localparam int B_DCE  = 6;
    localparam int B_HALT = 7;
    localparam int B_BERR = 8;
    localparam int B_IACK = 9;
    localparam int B_BUSY = 10;

    localparam logic [10:0] ONE       = 11'd1;
    localparam logic [10:0] P_IDLE    = 11'd0;
    localparam logic [10:0] P_FETCH   = (ONE << B_RD) | (ONE << B_BUSY);
    localparam logic [10:0] P_LATCH   = (ONE << B_RD) | (ONE << B_IR) | (ONE << B_INC) | (ONE << B_BUSY);
    localparam logic [10:0] P_DECODE  = (ONE << B_BUSY);
    localparam logic [10:0] P_OPERAND = (ONE << B_RD) | (ONE << B_BUSY);
    localparam logic [10:0] P_EXEC    = (ONE << B_RD) | (ONE << B_ACC) | (ONE << B_BUSY);
    localparam logic [10:0] P_STORE   = (ONE << B_WR) | (ONE << B_DCE) | (ONE << B_BUSY);
    localparam logic [10:0] P_JUMP    = (ONE << B_LPC) | (ONE << B_BUSY);
    localparam logic [10:0] P_SKIP    = (ONE << B_INC) | (ONE << B_BUSY);
    localparam logic [10:0] P_HALT    = (ONE << B_HALT);
    localparam logic [10:0] P_ERR     = (ONE << B_HALT) | (ONE << B_BERR);
    localparam logic [10:0] P_IRQ     = (ONE << B_LPC) | (ONE << B_IACK) | (ONE << B_BUSY);

    logic clk = 1'b0;
    logic rst = 1'b0;

    ctrl_fsm_ws_if #(.OPCODE_W(OPW)) bus_if ();

    ctrl_fsm_ws #(
        .OPCODE_W (OPW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_inc, cnt_acc, cnt_lpc, cnt_wr, cnt_dce, cnt_iack, cnt_berr, cnt_halt;
    logic [10:0] exp_q[$];
    logic [10:0] want_v;
    logic [10:0] act_v;

    function automatic logic [10:0] act_vec();
        logic [10:0] v;
        v = '0;
        v[B_INC]  = bus_if.inc_pc;
        v[B_ACC]  = bus_if.load_acc;
        v[B_LPC]  = bus_if.load_pc;
        v[B_RD]   = bus_if.rd;
        v[B_WR]   = bus_if.wr;
        v[B_IR]   = bus_if.load_ir;
        v[B_DCE]  = bus_if.datactl_ena;
        v[B_HALT] = bus_if.halt;
        v[B_BERR] = bus_if.bus_err;
        v[B_IACK] = bus_if.irq_ack;
        v[B_BUSY] = bus_if.busy;
        return v;
    endfunction

    // Per-cycle compare at posedge, half a cycle away from the negedge the DUT updates on.
    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            want_v = exp_q.pop_front();
            act_v  = act_vec();
            checks++;
            if (act_v !== want_v) begin
                errors++;
                $display("FAIL cycle t=%0t act=%b want=%b", $time, act_v, want_v);
            end
            cnt_inc  += int'(act_v[B_INC]);
            cnt_acc  += int'(act_v[B_ACC]);
            cnt_lpc  += int'(act_v[B_LPC]);
            cnt_wr   += int'(act_v[B_WR]);
            cnt_dce  += int'(act_v[B_DCE]);
            cnt_iack += int'(act_v[B_IACK]);
            cnt_berr += int'(act_v[B_BERR]);
            cnt_halt += int'(act_v[B_HALT]);
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s act=%0d want=%0d", nm, act, want);
        end
    endtask

    task automatic clr_cnt();
        cnt_inc = 0; cnt_acc = 0; cnt_lpc = 0; cnt_wr = 0;
        cnt_dce = 0; cnt_iack = 0; cnt_berr = 0; cnt_halt = 0;
    endtask

    // Drive inputs for the coming negedge and queue the strobe set it must produce.
    task automatic cyc(input logic e, input logic rdy, input logic [10:0] want);
        bus_if.ena       = e;
        bus_if.mem_ready = rdy;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
    endtask

    // 0 no-op, 1 alu, 2 hlt, 3 skz, 4 jmp, 5 sto
    function automatic int op_class(input int op);
        if (op > 15) return 0;
        case (op)
            0:       return 2;
            1:       return 3;
            9:       return 5;
            13:      return 4;
            default: return 1;
        endcase
    endfunction

    // Leaving an instruction: IRQ entry (if built in and requested) then a fetch.
    task automatic leave(input logic rdy, input bit irq_on);
`ifdef CTRL_IRQ_EN
        if (irq_on) begin
            cyc(1'b1, rdy, P_IRQ);
            cyc(1'b1, 1'b0, P_FETCH);
        end else begin
            cyc(1'b1, rdy, P_FETCH);
        end
`else
        if (irq_on) cyc(1'b1, rdy, P_FETCH);
        else        cyc(1'b1, rdy, P_FETCH);
`endif
    endtask

    // One instruction starting in FETCH; fw/ow/sw are wait cycles with mem_ready low.
    task automatic instr(input int op, input bit z, input int fw, input int ow,
                         input int sw, input bit irq_on);
        bus_if.opcode = OPW'(op);
        bus_if.zero   = z;
        bus_if.irq    = irq_on;
        repeat (fw) cyc(1'b1, 1'b0, P_FETCH);
        cyc(1'b1, 1'b1, P_LATCH);
        cyc(1'b1, 1'b0, P_DECODE);
        case (op_class(op))
            2: cyc(1'b1, 1'b0, P_HALT);
            3: begin
                if (z) cyc(1'b1, 1'b0, P_SKIP);
                if (z) leave(1'b0, irq_on);
                else   leave(1'b0, irq_on);
            end
            4: begin
                cyc(1'b1, 1'b0, P_JUMP);
                leave(1'b0, irq_on);
            end
            5: begin
                cyc(1'b1, 1'b0, P_STORE);
                repeat (sw) cyc(1'b1, 1'b0, P_STORE);
                leave(1'b1, irq_on);
            end
            1: begin
                cyc(1'b1, 1'b0, P_OPERAND);
                repeat (ow) cyc(1'b1, 1'b0, P_OPERAND);
                cyc(1'b1, 1'b1, P_EXEC);
                leave(1'b0, irq_on);
            end
            default: leave(1'b0, irq_on);
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.ena = 1'b0; bus_if.zero = 1'b0; bus_if.opcode = '0;
        bus_if.mem_ready = 1'b0; bus_if.irq = 1'b0;
        clr_cnt();
        #1 rst = 1'b1;
        #2 chk("reset_outputs", int'(act_vec()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, P_FETCH);

        clr_cnt();
        instr(2, 1'b0, 0, 0, 0, 1'b0);
        chk("add_load_acc", cnt_acc, 1);
        chk("add_inc_pc", cnt_inc, 1);

        clr_cnt();
        instr(9, 1'b0, 2, 0, 3, 1'b0);
        chk("sto_wr", cnt_wr, 4);
        chk("sto_dce", cnt_dce, 4);
        chk("sto_load_acc", cnt_acc, 0);

        clr_cnt();
        instr(1, 1'b1, 0, 0, 0, 1'b0);
        chk("skz_z1_inc", cnt_inc, 2);
        clr_cnt();
        instr(1, 1'b0, 0, 0, 0, 1'b0);
        chk("skz_z0_inc", cnt_inc, 1);

        clr_cnt();
        instr(13, 1'b0, 1, 0, 0, 1'b0);
        chk("jmp_load_pc", cnt_lpc, 1);

        clr_cnt();
        instr(18, 1'b0, 0, 0, 0, 1'b0);
        chk("wide_nop_acc", cnt_acc, 0);

        instr(10, 1'b0, TMO, TMO, 0, 1'b0);
        instr(9, 1'b0, TMO, 0, TMO, 1'b0);

        clr_cnt();
        instr(10, 1'b0, 0, 1, 0, 1'b1);
`ifdef CTRL_IRQ_EN
        chk("irq_ack_pulses", cnt_iack, 1);
        chk("irq_load_pc", cnt_lpc, 1);
`else
        chk("irq_ack_pulses", cnt_iack, 0);
        chk("irq_load_pc", cnt_lpc, 0);
`endif
        instr(7, 1'b0, 0, 0, 0, 1'b0);

        clr_cnt();
        bus_if.opcode = OPW'(9);
        cyc(1'b1, 1'b1, P_LATCH);
        cyc(1'b1, 1'b0, P_DECODE);
        cyc(1'b1, 1'b0, P_STORE);
        cyc(1'b1, 1'b0, P_STORE);
        cyc(1'b0, 1'b0, P_IDLE);
        cyc(1'b0, 1'b1, P_IDLE);
        chk("abort_store_wr", cnt_wr, 2);

        clr_cnt();
        bus_if.irq = 1'b1;
        cyc(1'b1, 1'b0, P_FETCH);
        repeat (TMO) cyc(1'b1, 1'b0, P_FETCH);
        cyc(1'b1, 1'b0, P_ERR);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i & 1), P_ERR);
        cyc(1'b0, 1'b0, P_IDLE);
        chk("timeout_bus_err", cnt_berr, 6);
        bus_if.irq = 1'b0;

        cyc(1'b1, 1'b0, P_FETCH);
        clr_cnt();
        instr(0, 1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'(i & 1), P_HALT);
        chk("halt_cycles", cnt_halt, 21);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", int'(act_vec()), 0);
        chk("async_reset_halt", int'(bus_if.halt), 0);
        rst = 1'b0;
        bus_if.irq = 1'b0;
        cyc(1'b1, 1'b0, P_FETCH);
        clr_cnt();
        instr(3, 1'b0, 0, 0, 0, 1'b0);
        chk("post_reset_acc", cnt_acc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
